// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter sharing one nibble-wide RAM with a tri-state data bus
module ram_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       we_a,
  input  logic [7:0] addr_a,
  input  logic [3:0] wdata_a,
  output logic       gnt_a,
  output logic       ack_a,
  output logic [3:0] rdata_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic [7:0] addr_b,
  input  logic [3:0] wdata_b,
  output logic       gnt_b,
  output logic       ack_b,
  output logic [3:0] rdata_b,
  output logic [7:0] mem_addr,
  output logic       mem_we,
  output logic       mem_re,
  output logic [3:0] mem_wdata,
  output logic       mem_wdata_oe,
  input  logic [3:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT} state_t;
  state_t state;
  logic last_b, owner_b, pick_a, sel_we;
  logic [3:0] cap;
  // a wins when alone, in fixed mode, or when b was granted last
  assign pick_a = req_a && (PRIORITY_MODE != 0 || !req_b || last_b);
  assign gnt_a = rst_n && state == IDLE && pick_a;
  assign gnt_b = rst_n && state == IDLE && req_b && !pick_a;
  assign sel_we = gnt_b ? we_b : we_a;
  // main sequencer: latch the winning request, run the RAM cycle, pulse ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      mem_wdata_oe <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
      last_b <= 1'b1;
      owner_b <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        IDLE: if (gnt_a || gnt_b) begin
          state <= ACCESS;
          owner_b <= gnt_b;
          last_b <= gnt_b;
          mem_addr <= gnt_b ? addr_b : addr_a;
          mem_wdata <= gnt_b ? wdata_b : wdata_a;
          mem_we <= sel_we;
          mem_wdata_oe <= sel_we;
          mem_re <= !sel_we;
        end
        ACCESS: begin
          state <= mem_we ? IDLE : READ_WAIT;
          mem_we <= 1'b0;
          mem_wdata_oe <= 1'b0;
          mem_re <= 1'b0;
          ack_a <= mem_we && !owner_b;
          ack_b <= mem_we && owner_b;
        end
        READ_WAIT: begin
          state <= IDLE;
          ack_a <= !owner_b;
          ack_b <= owner_b;
          rdata_a <= owner_b ? rdata_a : cap;
          rdata_b <= owner_b ? cap : rdata_b;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // sample the RAM read data mid-cycle while the RAM still drives the bus
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) cap <= '0;
    else if (state == READ_WAIT) cap <= mem_rdata;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: vectors, corner sequences and random traffic against a transaction-level model
module tb_ram_arbiter;
  logic clk = 0, rst_n = 1;
  logic ra = 0, rb = 0, wa = 0, wb = 0;
  logic [7:0] aa = 0, ab = 0;
  logic [3:0] da = 0, db = 0;
  logic gnt_a, gnt_b, ack_a, ack_b, mem_we, mem_re, mem_oe;
  logic [3:0] rdata_a, rdata_b, mem_wdata, mem_rdata;
  logic [7:0] mem_addr;
  logic f_gnt_a, f_gnt_b, f_ack_a, f_ack_b, f_we, f_re, f_oe;
  logic [3:0] f_rd_a, f_rd_b, f_wdata;
  logic [7:0] f_addr;
  logic [3:0] zero4 = 4'h0;

  ram_arbiter #(.PRIORITY_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req_a(ra), .we_a(wa), .addr_a(aa), .wdata_a(da), .gnt_a(gnt_a), .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(rb), .we_b(wb), .addr_b(ab), .wdata_b(db), .gnt_b(gnt_b), .ack_b(ack_b), .rdata_b(rdata_b),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
    .mem_wdata_oe(mem_oe), .mem_rdata(mem_rdata));

  ram_arbiter #(.PRIORITY_MODE(1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req_a(ra), .we_a(wa), .addr_a(aa), .wdata_a(da), .gnt_a(f_gnt_a), .ack_a(f_ack_a), .rdata_a(f_rd_a),
    .req_b(rb), .we_b(wb), .addr_b(ab), .wdata_b(db), .gnt_b(f_gnt_b), .ack_b(f_ack_b), .rdata_b(f_rd_b),
    .mem_addr(f_addr), .mem_we(f_we), .mem_re(f_re), .mem_wdata(f_wdata),
    .mem_wdata_oe(f_oe), .mem_rdata(zero4));

  always #5 clk = ~clk;

  // external RAM: writes on falling edge, captures reads on rising edge, drives bus until next falling edge
  logic [3:0] ram [256];
  logic [3:0] drv_d = 0;
  logic rtok = 0, ntok = 0;
  always @(negedge clk) begin
    if (mem_we && mem_oe) ram[mem_addr] = mem_wdata;
    ntok <= rtok;
  end
  always @(posedge clk) if (mem_re) begin
    drv_d <= ram[mem_addr];
    rtok <= ~rtok;
  end
  assign mem_rdata = (rtok != ntok) ? drv_d : 4'h6;

  // transaction-level reference state
  logic [3:0] ref_mem [256];
  int cyc_n = 0, free_r = 0, free_f = 0, p_at = -10, f_at = -10;
  bit last_b = 1, p_b, p_rd, f_b, g_a, g_b;
  logic [3:0] p_data = 0, x_rd_a = 0, x_rd_b = 0, x_wd = 0;
  logic [7:0] x_addr = 0;
  int nvec = 0, nmis = 0;

  typedef struct {bit port; bit we; logic [7:0] addr; logic [3:0] wd; logic [3:0] exp;} vec_t;
  vec_t tbl [8];

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc_n);
    end
  endtask

  task automatic cyc;
    bit ea, eb, fa, fb, w;
    logic [7:0] a;
    #1;
    ea = cyc_n >= free_r && ra && (!rb || last_b);
    eb = cyc_n >= free_r && rb && !ea;
    fa = cyc_n >= free_f && ra;
    fb = cyc_n >= free_f && rb && !ra;
    chk("gnt_a", gnt_a, ea);
    chk("gnt_b", gnt_b, eb);
    chk("fix_gnt_a", f_gnt_a, fa);
    chk("fix_gnt_b", f_gnt_b, fb);
    g_a = gnt_a;
    g_b = gnt_b;
    if (ea || eb) begin
      w = eb ? wb : wa;
      a = eb ? ab : aa;
      free_r = cyc_n + (w ? 2 : 3);
      p_at = free_r;
      p_b = eb;
      p_rd = !w;
      last_b = eb;
      x_addr = a;
      if (w) begin
        x_wd = eb ? db : da;
        ref_mem[a] = x_wd;
      end else p_data = ref_mem[a];
    end
    if (fa || fb) begin
      free_f = cyc_n + ((fb ? wb : wa) ? 2 : 3);
      f_at = free_f;
      f_b = fb;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (p_at == cyc_n && p_rd) begin
      if (p_b) x_rd_b = p_data;
      else x_rd_a = p_data;
    end
    chk("ack_a", ack_a, p_at == cyc_n && !p_b);
    chk("ack_b", ack_b, p_at == cyc_n && p_b);
    chk("fix_ack_a", f_ack_a, f_at == cyc_n && !f_b);
    chk("fix_ack_b", f_ack_b, f_at == cyc_n && f_b);
    chk("rdata_a", rdata_a, x_rd_a);
    chk("rdata_b", rdata_b, x_rd_b);
    chk("mem_addr", mem_addr, x_addr);
    chk("mem_we", mem_we, p_at == cyc_n + 1 && !p_rd);
    chk("mem_wdata_oe", mem_oe, p_at == cyc_n + 1 && !p_rd);
    chk("mem_re", mem_re, p_at == cyc_n + 2 && p_rd);
    if (mem_we) chk("mem_wdata", mem_wdata, x_wd);
  endtask

  task automatic do_reset;
    ra = 0;
    rb = 0;
    rst_n = 0;
    #1;
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_oe", mem_oe, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata_a", rdata_a, 0);
    chk("rst_rdata_b", rdata_b, 0);
    chk("rst_fix_ack_a", f_ack_a, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_ack_a", ack_a, 0);
    rst_n = 1;
    free_r = cyc_n;
    free_f = cyc_n;
    p_at = -10;
    f_at = -10;
    last_b = 1;
    x_addr = 0;
    x_rd_a = 0;
    x_rd_b = 0;
  endtask

  initial begin
    int q[$];
    int fbn;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 4'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[0] = 4'h9;
    ref_mem[0] = 4'h9;
    tbl[0] = '{0, 1, 8'h3C, 4'hA, 4'h0};
    tbl[1] = '{0, 0, 8'h3C, 4'h0, 4'hA};
    tbl[2] = '{1, 1, 8'hFF, 4'h5, 4'h0};
    tbl[3] = '{1, 0, 8'hFF, 4'h0, 4'h5};
    tbl[4] = '{0, 0, 8'h00, 4'h0, 4'h9};
    tbl[5] = '{1, 1, 8'h00, 4'h3, 4'h0};
    tbl[6] = '{0, 0, 8'h00, 4'h0, 4'h3};
    tbl[7] = '{1, 0, 8'h3C, 4'h0, 4'hA};
    @(posedge clk);
    #1;
    do_reset();
    // back-to-back: write 0xF to 0xFF, read 0x00 in the ack cycle
    ra = 1; wa = 1; aa = 8'hFF; da = 4'hF;
    cyc();
    ra = 0;
    cyc();
    chk("b2b_ack", ack_a, 1);
    ra = 1; wa = 0; aa = 8'h00;
    cyc();
    chk("b2b_gnt", g_a, 1);
    ra = 0;
    cyc();
    cyc();
    chk("b2b_rd_ack", ack_a, 1);
    chk("b2b_rdata", rdata_a, 4'h9);
    // vector table: one complete transaction per record
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].port) begin rb = 1; wb = tbl[t].we; ab = tbl[t].addr; db = tbl[t].wd; end
      else begin ra = 1; wa = tbl[t].we; aa = tbl[t].addr; da = tbl[t].wd; end
      cyc();
      chk("tbl_gnt", tbl[t].port ? g_b : g_a, 1);
      ra = 0;
      rb = 0;
      repeat (tbl[t].we ? 1 : 2) cyc();
      chk("tbl_ack", tbl[t].port ? ack_b : ack_a, 1);
      if (!tbl[t].we) chk("tbl_rdata", tbl[t].port ? rdata_b : rdata_a, tbl[t].exp);
    end
    // continuous tie from reset: round-robin alternates, fixed never grants b
    do_reset();
    ra = 1; rb = 1; wa = 1; wb = 1; aa = 8'h10; ab = 8'h20; da = 4'h1; db = 4'h2;
    fbn = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (g_a) q.push_back(0);
      if (g_b) q.push_back(1);
      if (f_gnt_b) fbn++;
    end
    chk("rr_count", 8'(q.size()), 4);
    foreach (q[i]) chk("rr_order", 8'(q[i]), 8'(i % 2));
    chk("fix_starve", 8'(fbn), 0);
    ra = 0; rb = 0;
    repeat (3) cyc();
    // reset during READ_WAIT abandons the read; a wins the next tie
    ra = 1; wa = 0; aa = 8'h3C;
    cyc();
    ra = 0;
    cyc();
    do_reset();
    ra = 1; rb = 1; wa = 0; wb = 0; aa = 8'h05; ab = 8'h06;
    cyc();
    chk("post_rst_tie", g_a, 1);
    ra = 0; rb = 0;
    repeat (3) cyc();
    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      ra = 1'($urandom); rb = 1'($urandom); wa = 1'($urandom); wb = 1'($urandom);
      aa = 8'($urandom_range(0, 15)); ab = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) aa = 8'hFF;
      da = 4'($urandom); db = 4'($urandom);
      cyc();
    end
    ra = 0; rb = 0;
    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter PRIORITY_MODE, default 0, meaning 0 = round-robin and 1 = fixed priority with port A always winning.
REQ-002 SHALL have port clk, input, 1 bit: single clock; every register updates on its rising edge except the REQ-019 capture register.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have, per port x in {a,b}, input req_x, 1 bit: access request, held until ack_x.
REQ-005 SHALL have input we_x, 1 bit: 1 = write, 0 = read.
REQ-006 SHALL have input addr_x, 8 bits: nibble address 0-255.
REQ-007 SHALL have input wdata_x, 4 bits: write nibble.
REQ-008 SHALL have output gnt_x, 1 bit: request accepted this cycle.
REQ-009 SHALL have output ack_x, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have output rdata_x, 4 bits: read nibble, valid while ack_x is high for a read.
REQ-011 SHALL have output mem_addr, 8 bits: RAM address.
REQ-012 SHALL have output mem_we, 1 bit: RAM write_enable.
REQ-013 SHALL have output mem_re, 1 bit: RAM read_enable.
REQ-014 SHALL have outputs mem_wdata (4 bits) and mem_wdata_oe (1 bit): write nibble and bus-drive enable, for the external tri-state buffer.
REQ-015 SHALL have input mem_rdata, 4 bits: shared RAM data bus as seen by the controller.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and READ_WAIT, with transitions IDLE->ACCESS on any grant, ACCESS->READ_WAIT for a read, ACCESS->IDLE for a write, and READ_WAIT->IDLE unconditionally.
REQ-017 SHALL assert gnt_x combinationally only in IDLE, to at most one port, and at the rising edge where gnt_x=1 SHALL latch addr_x, we_x and wdata_x into mem_addr, mem_we and mem_wdata together with the owner id.
REQ-018 SHALL, in ACCESS for a write, drive mem_we=1 and mem_wdata_oe=1 so that the RAM writes at the falling edge mid-ACCESS; for a read it SHALL drive mem_we=0 and mem_re=1 so that the RAM captures at the rising edge that ends ACCESS.
REQ-019 SHALL, in READ_WAIT, sample mem_rdata into a capture register on the falling edge of clk, while the RAM is still driving the bus (clk high).
REQ-020 SHALL drive mem_we, mem_re and mem_wdata_oe to 0 in IDLE and READ_WAIT, and SHALL hold mem_addr at its last value.
REQ-021 SHALL meet these latencies, with grant at cycle T:
  - write: ack_x is high in cycle T+2.
  - read: ack_x is high in cycle T+3, with rdata_x equal to the captured nibble.
  - ack_x is registered and pulses for exactly one cycle.
REQ-022 SHALL hold rdata_x at its last value between acks; for a write ack, rdata_x SHALL be unchanged.
REQ-023 SHALL allow a new grant in the same IDLE cycle in which the previous ack is high, giving back-to-back throughput of 1 write per 2 cycles and 1 read per 3 cycles.
REQ-024 SHALL, in round-robin mode, grant the port not granted most recently when both ports request, and a lone requester SHALL always win; the last-grant pointer SHALL update only on a grant.
REQ-025 SHALL, in fixed mode, grant port a whenever req_a=1, so port b can starve.
REQ-026 SHALL ignore req_x outside IDLE, with no queuing; a port deasserting req before gnt SHALL cancel its request silently.
REQ-027 SHALL never let mem_wdata_oe and the RAM read-drive window overlap: mem_wdata_oe is 1 only in write-ACCESS.

Reset
REQ-028 SHALL, on rst_n=0 and asynchronously:
  - set the state to IDLE.
  - set gnt, ack, mem_we, mem_re and mem_wdata_oe to 0.
  - set mem_addr, mem_wdata, rdata_a and rdata_b to 0.
  - set the last-grant pointer to b, so port a wins the first tie.
REQ-029 SHALL, when reset asserts mid-operation, abandon the access without acknowledging it; the write SHALL NOT be re-issued.
REQ-030 SHALL resume operation on the first rising edge after rst_n deasserts, starting in IDLE.

Verification
REQ-031 SHALL cover a single write: a writes 0xA to address 0x3C -> gnt_a at T, mem_we=1 and mem_wdata_oe=1 in T+1, ack_a in T+2.
REQ-032 SHALL cover read-back: a reads 0x3C after that write -> ack_a at T+3 with rdata_a=0xA, and mem_we=0 throughout.
REQ-033 SHALL cover a tie in round-robin mode: a and b request continuously from reset -> grants alternate a, b, a, b.
REQ-034 SHALL cover a tie in fixed mode: PRIORITY_MODE=1 with both ports requesting -> port b is never granted while req_a=1.
REQ-035 SHALL cover boundary addresses and a back-to-back pair: write 0xF to address 0xFF, then read address 0x00 in the ack cycle -> second grant in the same cycle as the first ack; read returns the nibble preloaded at 0x00.
REQ-036 SHALL cover reset mid-operation: rst_n pulled low in READ_WAIT -> all enables and acks are 0 immediately, no ack for the read, and port a wins the next tie.
